// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the execute stage.
// Holds the ALU opcode, RV32M funct3 and MD FSM state encodings, plus ALU/MD field widths.
package ex_pkg;
    localparam int ALU_OP_W = 4;
    localparam int MD_OP_W  = 3;
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;
    typedef enum logic [MD_OP_W-1:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;
endpackage

// File: rtl/ex_stage_md_md.sv
// md_iter_unit: iterative RV32M multiply/divide, one bit per cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/op_i/a_i/b_i launch an op in IDLE;
// flush_i aborts to IDLE; ack_i releases DONE; busy_o = not IDLE; done_o = DONE; result_o valid in DONE.
module md_iter_unit
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic            ack_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);
    md_state_e         r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc, w_step, w_prod;
    logic [XLEN-1:0]   r_b, w_a_mag, w_b_mag, w_quo, w_rem;
    logic [2:0]        r_op;
    logic              r_neg, w_neg, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN:0]     w_sum, w_shift, w_diff;

    // op[2] splits divide from multiply; MULHSU keeps rs2 unsigned, MULHU/DIVU/REMU both
    assign w_a_sgn = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    assign w_b_sgn = op_i[2] ? ~op_i[0] : ~op_i[1];
    assign w_a_neg = w_a_sgn & a_i[XLEN-1];
    assign w_b_neg = w_b_sgn & b_i[XLEN-1];
    assign w_a_mag = w_a_neg ? -a_i : a_i;
    assign w_b_mag = w_b_neg ? -b_i : b_i;
    // remainder follows the dividend; a zero divisor leaves the all-ones quotient unsigned
    assign w_neg = (op_i[2] & op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg) & (~op_i[2] | (|b_i));

    // shift-add: upper half accumulates the multiplicand when the multiplier lsb is set
    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // restoring divide: upper half is the partial remainder, lower half shifts in quotient bits
    assign w_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_step  = (r_state == MUL) ? {w_sum, r_acc[XLEN-1:1]}
                   : w_diff[XLEN]     ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                   :                    {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_prod   = r_neg ? -r_acc : r_acc;
    assign w_quo    = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem    = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign result_o = !r_op[2] ? ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN])
                    : r_op[1] ? w_rem : w_quo;
    assign busy_o   = (r_state != IDLE);
    assign done_o   = (r_state == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = flush_i             ? IDLE
               : (r_state == IDLE)   ? (start_i ? (op_i[2] ? DIV : MUL) : IDLE)
               : (r_state == DONE)   ? (ack_i ? IDLE : DONE)
               : (r_cnt == CW'(XLEN-1)) ? DONE
               : r_state;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_neg <= 1'b0;
        end else if (r_state == IDLE && start_i) begin
            r_cnt <= '0;
            r_acc <= {{XLEN{1'b0}}, w_a_mag};
            r_b   <= w_b_mag;
            r_op  <= op_i;
            r_neg <= w_neg;
        end else if (r_state == MUL || r_state == DIV) begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= w_step;
        end
    end
endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with forwarding mux, ALU, branch compare, iterative RV32M unit and EX/MEM register.
// Ports: clk_i/rst_ni; enable_i advances, flush_i kills; valid_i/ready_o ID handshake; rs1/rs2/imm/pc/pc4 and
// fwd_data_i with fwd_sel_a/b select operands; asel/bsel/alu_sel/br_un steer the ALU and compare; md_en/md_op pick
// an M op; rd/regwen/memrw/wbsel/inst ride along; *_o registered EX/MEM outputs, alu_o/breq_o/brlt_o combinational.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter bit MD_EN   = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [XLEN-1:0]            rs1_i,
    input  logic [XLEN-1:0]            rs2_i,
    input  logic [XLEN-1:0]            imm_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            pc4_i,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_data_i,
    input  logic [$clog2(NUM_FWD+1)-1:0] fwd_sel_a_i,
    input  logic [$clog2(NUM_FWD+1)-1:0] fwd_sel_b_i,
    input  logic                       asel_i,
    input  logic                       bsel_i,
    input  logic [3:0]                 alu_sel_i,
    input  logic                       br_un_i,
    input  logic                       md_en_i,
    input  logic [2:0]                 md_op_i,
    input  logic [4:0]                 rd_i,
    input  logic                       regwen_i,
    input  logic                       memrw_i,
    input  logic [1:0]                 wbsel_i,
    input  logic [31:0]                inst_i,
    output logic                       valid_o,
    output logic [XLEN-1:0]            result_o,
    output logic [XLEN-1:0]            rs2_o,
    output logic [XLEN-1:0]            pc4_o,
    output logic [4:0]                 rd_o,
    output logic                       regwen_o,
    output logic                       memrw_o,
    output logic [1:0]                 wbsel_o,
    output logic [31:0]                inst_o,
    output logic [XLEN-1:0]            alu_o,
    output logic                       breq_o,
    output logic                       brlt_o,
    output logic                       busy_o
);
    localparam int SW  = $clog2(NUM_FWD+1);
    localparam int SHW = $clog2(XLEN);
    logic [XLEN-1:0] w_fa, w_fb, w_op_a, w_op_b, w_alu, w_md_res;
    logic [SHW-1:0]  w_shamt;
    logic            w_md, w_accept, w_alu_acc, w_busy, w_done;
    logic [XLEN-1:0] r_result, r_rs2, r_pc4, r_cap_rs2, r_cap_pc4;
    logic [31:0]     r_inst, r_cap_inst;
    logic [4:0]      r_rd, r_cap_rd;
    logic [1:0]      r_wbsel, r_cap_wbsel;
    logic            r_valid, r_regwen, r_memrw, r_cap_regwen, r_cap_memrw;

    // unmatched selects (0 or above NUM_FWD) fall back to the register file
    always_comb begin
        w_fa = rs1_i;
        w_fb = rs2_i;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (fwd_sel_a_i == SW'(k + 1)) w_fa = fwd_data_i[k*XLEN +: XLEN];
            if (fwd_sel_b_i == SW'(k + 1)) w_fb = fwd_data_i[k*XLEN +: XLEN];
        end
    end

    assign w_op_a  = asel_i ? pc_i : w_fa;
    assign w_op_b  = bsel_i ? imm_i : w_fb;
    assign w_shamt = w_op_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (alu_op_e'(alu_sel_i))
            ALU_ADD:   w_alu = w_op_a + w_op_b;
            ALU_SUB:   w_alu = w_op_a - w_op_b;
            ALU_SLL:   w_alu = w_op_a << w_shamt;
            ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
            ALU_XOR:   w_alu = w_op_a ^ w_op_b;
            ALU_SRL:   w_alu = w_op_a >> w_shamt;
            ALU_SRA:   w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_OR:    w_alu = w_op_a | w_op_b;
            ALU_AND:   w_alu = w_op_a & w_op_b;
            ALU_PASSB: w_alu = w_op_b;
            default:   w_alu = '0;
        endcase
    end

    assign alu_o  = w_alu;
    assign breq_o = (w_fa == w_fb);
    assign brlt_o = br_un_i ? (w_fa < w_fb) : ($signed(w_fa) < $signed(w_fb));

    // a flush in the accept cycle discards the instruction
    assign w_md      = MD_EN & md_en_i;
    assign w_accept  = valid_i & enable_i & ready_o & ~flush_i;
    assign w_alu_acc = w_accept & ~w_md;
    assign ready_o   = ~w_busy;
    assign busy_o    = w_busy;

    generate
        if (MD_EN) begin : g_md
            md_iter_unit #(.XLEN(XLEN)) u_md (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .start_i  (w_accept & w_md),
                .flush_i  (flush_i),
                .ack_i    (enable_i),
                .op_i     (md_op_i),
                .a_i      (w_fa),
                .b_i      (w_fb),
                .busy_o   (w_busy),
                .done_o   (w_done),
                .result_o (w_md_res)
            );
        end else begin : g_no_md
            assign w_busy   = 1'b0;
            assign w_done   = 1'b0;
            assign w_md_res = '0;
        end
    endgenerate

    // control of an M op is held here until its result is ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cap_rd     <= '0;
            r_cap_regwen <= 1'b0;
            r_cap_memrw  <= 1'b0;
            r_cap_wbsel  <= '0;
            r_cap_inst   <= '0;
            r_cap_rs2    <= '0;
            r_cap_pc4    <= '0;
        end else if (w_accept && w_md) begin
            r_cap_rd     <= rd_i;
            r_cap_regwen <= regwen_i;
            r_cap_memrw  <= memrw_i;
            r_cap_wbsel  <= wbsel_i;
            r_cap_inst   <= inst_i;
            r_cap_rs2    <= w_fb;
            r_cap_pc4    <= pc4_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid  <= 1'b0;
            r_regwen <= 1'b0;
            r_memrw  <= 1'b0;
            r_result <= '0;
            r_rs2    <= '0;
            r_pc4    <= '0;
            r_rd     <= '0;
            r_wbsel  <= '0;
            r_inst   <= '0;
        end else if (flush_i || (enable_i && !w_done && !w_alu_acc)) begin
            r_valid  <= 1'b0;
            r_regwen <= 1'b0;
            r_memrw  <= 1'b0;
        end else if (enable_i) begin
            r_valid  <= 1'b1;
            r_regwen <= w_done ? r_cap_regwen : regwen_i;
            r_memrw  <= w_done ? r_cap_memrw : memrw_i;
            r_result <= w_done ? w_md_res : w_alu;
            r_rs2    <= w_done ? r_cap_rs2 : w_fb;
            r_pc4    <= w_done ? r_cap_pc4 : pc4_i;
            r_rd     <= w_done ? r_cap_rd : rd_i;
            r_wbsel  <= w_done ? r_cap_wbsel : wbsel_i;
            r_inst   <= w_done ? r_cap_inst : inst_i;
        end
    end

    assign valid_o  = r_valid;
    assign regwen_o = r_regwen;
    assign memrw_o  = r_memrw;
    assign result_o = r_result;
    assign rs2_o    = r_rs2;
    assign pc4_o    = r_pc4;
    assign rd_o     = r_rd;
    assign wbsel_o  = r_wbsel;
    assign inst_o   = r_inst;
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: table-driven ALU vectors, directed M-op corner cases and randomized M ops against an arithmetic model.
module tb_ex_stage_md;
    import ex_pkg::*;
    logic        clk_i = 1'b0, rst_ni = 1'b0, enable_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_o;
    logic [31:0] rs1_i = '0, rs2_i = '0, imm_i = '0, pc_i = '0, pc4_i = '0;
    logic [63:0] fwd_data_i = '0;
    logic [1:0]  fwd_sel_a_i = '0, fwd_sel_b_i = '0, wbsel_i = '0, wbsel_o;
    logic        asel_i = 1'b0, bsel_i = 1'b0, br_un_i = 1'b0, md_en_i = 1'b0, regwen_i = 1'b0, memrw_i = 1'b0;
    logic [3:0]  alu_sel_i = '0;
    logic [2:0]  md_op_i = '0;
    logic [4:0]  rd_i = '0, rd_o;
    logic [31:0] inst_i = '0, inst_o, result_o, rs2_o, pc4_o, alu_o;
    logic        valid_o, regwen_o, memrw_o, breq_o, brlt_o, busy_o;
    int checks = 0, errors = 0;

    ex_stage_md #(.XLEN(32), .NUM_FWD(2), .MD_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .pc_i(pc_i), .pc4_i(pc4_i),
        .fwd_data_i(fwd_data_i), .fwd_sel_a_i(fwd_sel_a_i), .fwd_sel_b_i(fwd_sel_b_i), .asel_i(asel_i),
        .bsel_i(bsel_i), .alu_sel_i(alu_sel_i), .br_un_i(br_un_i), .md_en_i(md_en_i), .md_op_i(md_op_i),
        .rd_i(rd_i), .regwen_i(regwen_i), .memrw_i(memrw_i), .wbsel_i(wbsel_i), .inst_i(inst_i),
        .valid_o(valid_o), .result_o(result_o), .rs2_o(rs2_o), .pc4_o(pc4_o), .rd_o(rd_o),
        .regwen_o(regwen_o), .memrw_o(memrw_o), .wbsel_o(wbsel_o), .inst_o(inst_o), .alu_o(alu_o),
        .breq_o(breq_o), .brlt_o(brlt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  op;
        logic        asel, bsel, brun;
        logic [1:0]  fsa, fsb;
        logic [31:0] rs1, rs2, imm, pc, f0, f1, exp_res, exp_rs2;
        logic        eq, lt;
    } vec_t;
    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // launch an M op and wait (bounded) for its EX/MEM result
    task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int rlow);
        valid_i = 1'b1; md_en_i = 1'b1; md_op_i = op; rs1_i = a; rs2_i = b;
        fwd_sel_a_i = '0; fwd_sel_b_i = '0; rd_i = 5'd9; regwen_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0;
        chk("md_ready_idle", 32'(ready_o), 1);
        tick();
        valid_i = 1'b0; md_en_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; rd_i = '0; regwen_i = 1'b0;
        lat = 1;
        rlow = ready_o ? 0 : 1;
        while (!valid_o && lat < 100) begin
            tick();
            lat++;
            if (!ready_o) rlow++;
        end
        res = result_o;
        chk("md_valid", 32'(valid_o), 1);
        chk("md_rd", 32'(rd_o), 9);
        chk("md_rs2", rs2_o, b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int lat, rlow, cnt;
        logic [2:0] op;
        logic [31:0] a, b;
        vt[0]  = '{ALU_ADD,   0, 0, 0, 1, 0, 32'd100,      32'd7,        0, 0, 32'd5,    0,       32'd12,       32'd7,        0, 1};
        vt[1]  = '{ALU_SUB,   0, 0, 0, 0, 0, 32'd10,       32'd3,        0, 0, 0,        0,       32'd7,        32'd3,        0, 0};
        vt[2]  = '{ALU_SLL,   0, 0, 0, 0, 0, 32'd1,        32'd36,       0, 0, 0,        0,       32'd16,       32'd36,       0, 1};
        vt[3]  = '{ALU_SLT,   0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        0, 0, 0,        0,       32'd1,        32'd1,        0, 1};
        vt[4]  = '{ALU_SLTU,  0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'd1,        0, 0, 0,        0,       32'd0,        32'd1,        0, 0};
        vt[5]  = '{ALU_XOR,   0, 0, 0, 0, 0, 32'h0000F0F0, 32'h0000FF00, 0, 0, 0,        0,       32'h00000FF0, 32'h0000FF00, 0, 1};
        vt[6]  = '{ALU_SRA,   0, 0, 0, 0, 0, 32'h80000000, 32'd4,        0, 0, 0,        0,       32'hF8000000, 32'd4,        0, 1};
        vt[7]  = '{ALU_SRL,   0, 0, 1, 0, 0, 32'h80000000, 32'd4,        0, 0, 0,        0,       32'h08000000, 32'd4,        0, 0};
        vt[8]  = '{ALU_AND,   0, 0, 0, 0, 0, 32'hFF00FF00, 32'h0F0F0F0F, 0, 0, 0,        0,       32'h0F000F00, 32'h0F0F0F0F, 0, 1};
        vt[9]  = '{ALU_ADD,   1, 1, 0, 0, 0, 32'd5,        32'd5,        32'h10, 32'h1000, 0, 0,  32'h1010,     32'd5,        1, 0};
        vt[10] = '{ALU_ADD,   0, 0, 0, 0, 2, 32'd3,        32'd99,       0, 0, 0,        32'h20,  32'h23,       32'h20,       0, 1};
        vt[11] = '{ALU_ADD,   0, 0, 0, 3, 0, 32'h11,       32'h22,       0, 0, 32'hDEAD, 32'hBEEF, 32'h33,      32'h22,       0, 1};
        vt[12] = '{ALU_PASSB, 0, 1, 0, 0, 0, 32'd0,        32'd0,        32'h12345000, 0, 0, 0,   32'h12345000, 32'd0,        1, 0};
        vt[13] = '{ALU_OR,    0, 0, 0, 2, 1, 32'd0,        32'd0,        0, 0, 32'h0F,   32'hF0,  32'hFF,       32'h0F,       0, 0};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_result", result_o, 0);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_regwen", 32'(regwen_o), 0);
        rst_ni = 1'b1;
        tick();

        foreach (vt[i]) begin
            alu_sel_i = vt[i].op; asel_i = vt[i].asel; bsel_i = vt[i].bsel; br_un_i = vt[i].brun;
            fwd_sel_a_i = vt[i].fsa; fwd_sel_b_i = vt[i].fsb; rs1_i = vt[i].rs1; rs2_i = vt[i].rs2;
            imm_i = vt[i].imm; pc_i = vt[i].pc; pc4_i = vt[i].pc + 4; fwd_data_i = {vt[i].f1, vt[i].f0};
            rd_i = 5'(i + 1); regwen_i = 1'b1; inst_i = 32'(i); valid_i = 1'b1; md_en_i = 1'b0;
            #1;
            chk($sformatf("alu_o[%0d]", i), alu_o, vt[i].exp_res);
            chk($sformatf("breq[%0d]", i), 32'(breq_o), 32'(vt[i].eq));
            chk($sformatf("brlt[%0d]", i), 32'(brlt_o), 32'(vt[i].lt));
            tick();
            chk($sformatf("result[%0d]", i), result_o, vt[i].exp_res);
            chk($sformatf("valid[%0d]", i), 32'(valid_o), 1);
            chk($sformatf("rs2_o[%0d]", i), rs2_o, vt[i].exp_rs2);
            chk($sformatf("rd_o[%0d]", i), 32'(rd_o), 32'(i + 1));
            chk($sformatf("pc4_o[%0d]", i), pc4_o, vt[i].pc + 4);
        end
        valid_i = 1'b0; asel_i = 1'b0; bsel_i = 1'b0; fwd_sel_a_i = '0; fwd_sel_b_i = '0; regwen_i = 1'b0;
        tick();
        chk("bubble_valid", 32'(valid_o), 0);
        chk("bubble_regwen", 32'(regwen_o), 0);

        md_run(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, rlow);
        chk("mulhu", res, 32'hFFFFFFFE);
        chk("md_latency", 32'(lat), 34);
        chk("md_ready_low", 32'(rlow), 33);
        md_run(MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, rlow);
        chk("mulh", res, 32'h0);
        md_run(MD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, rlow);
        chk("mul", res, 32'h1);
        md_run(MD_DIV, 32'hFFFFFFF9, 32'd2, res, lat, rlow);
        chk("div_m7_2", res, 32'hFFFFFFFD);
        chk("div_latency", 32'(lat), 34);
        md_run(MD_REM, 32'hFFFFFFF9, 32'd2, res, lat, rlow);
        chk("rem_m7_2", res, 32'hFFFFFFFF);
        md_run(MD_DIVU, 32'd1234, 32'd0, res, lat, rlow);
        chk("divu_by0", res, 32'hFFFFFFFF);
        md_run(MD_DIV, 32'hFFFFFFF0, 32'd0, res, lat, rlow);
        chk("div_by0", res, 32'hFFFFFFFF);
        md_run(MD_REM, 32'hFFFFFFF0, 32'd0, res, lat, rlow);
        chk("rem_by0", res, 32'hFFFFFFF0);
        md_run(MD_DIV, 32'h80000000, 32'hFFFFFFFF, res, lat, rlow);
        chk("div_ovf", res, 32'h80000000);
        md_run(MD_REM, 32'h80000000, 32'hFFFFFFFF, res, lat, rlow);
        chk("rem_ovf", res, 32'h0);

        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            md_run(op, a, b, res, lat, rlow);
            chk($sformatf("rand op%0d %h,%h", op, a, b), res, md_model(op, a, b));
        end

        // enable low from cycle 5 to 40: result must wait in DONE
        valid_i = 1'b1; md_en_i = 1'b1; md_op_i = MD_DIV; rs1_i = 32'hFFFFFFF9; rs2_i = 32'd2; rd_i = 5'd3; regwen_i = 1'b1;
        tick();
        valid_i = 1'b0; md_en_i = 1'b0; rd_i = '0; regwen_i = 1'b0;
        repeat (4) tick();
        enable_i = 1'b0;
        repeat (36) tick();
        chk("stall_valid", 32'(valid_o), 0);
        chk("stall_busy", 32'(busy_o), 1);
        chk("stall_ready", 32'(ready_o), 0);
        enable_i = 1'b1;
        tick();
        chk("stall_release_valid", 32'(valid_o), 1);
        chk("stall_release_result", result_o, 32'hFFFFFFFD);
        chk("stall_release_rd", 32'(rd_o), 3);

        // flush at cycle 10 of a divide
        valid_i = 1'b1; md_en_i = 1'b1; md_op_i = MD_DIVU; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd4; regwen_i = 1'b1;
        tick();
        valid_i = 1'b0; md_en_i = 1'b0; regwen_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 0);
        chk("flush_valid", 32'(valid_o), 0);
        chk("flush_regwen", 32'(regwen_o), 0);
        valid_i = 1'b1; alu_sel_i = ALU_ADD; rs1_i = 32'd2; rs2_i = 32'd3; rd_i = 5'd6; regwen_i = 1'b1;
        tick();
        chk("post_flush_add", result_o, 32'd5);
        chk("post_flush_valid", 32'(valid_o), 1);
        valid_i = 1'b0; regwen_i = 1'b0;
        cnt = 0;
        repeat (40) begin
            tick();
            if (valid_o) cnt++;
        end
        chk("flush_no_stray", 32'(cnt), 0);

        // flush together with an accept discards the M op
        valid_i = 1'b1; md_en_i = 1'b1; md_op_i = MD_MUL; flush_i = 1'b1;
        tick();
        valid_i = 1'b0; md_en_i = 1'b0; flush_i = 1'b0;
        chk("flush_accept_busy", 32'(busy_o), 0);

        // async reset in the middle of a multiply
        valid_i = 1'b1; md_en_i = 1'b1; md_op_i = MD_MUL; rs1_i = 32'd3; rs2_i = 32'd5; rd_i = 5'd9; regwen_i = 1'b1;
        tick();
        valid_i = 1'b0; md_en_i = 1'b0; regwen_i = 1'b0;
        repeat (10) tick();
        chk("pre_rst_busy", 32'(busy_o), 1);
        chk("pre_rst_result", result_o, 32'd5);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_result", result_o, 0);
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_rd", 32'(rd_o), 0);
        chk("arst_pc4", pc4_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("post_rst_ready", 32'(ready_o), 1);
        cnt = 0;
        repeat (40) begin
            tick();
            if (valid_o || regwen_o) cnt++;
        end
        chk("rst_no_result", 32'(cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
